// File: rtl/tartaruga_pkg.sv
// Shared constants and the queued fetch entry type for the fetch front end.
package tartaruga_pkg;

    localparam logic [31:0] NOP_INSTR_HEX    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fifo_sync.sv
// Small synchronous FIFO with flush; head is read combinationally so a push is
// visible on rdata_o the cycle after it is written.
module fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && rd_en) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch unit: credit-limited in-order requests, PC/instruction queue,
// and redirect handling that drops responses to requests issued before it.
module fetch_buffer
    import tartaruga_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        taken_branch_i,
    input  logic [31:0] new_pc_i,
    input  logic        stall_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    logic [31:0]        pc_q, pc_d;
    logic [CW-1:0]      out_q, out_d;
    logic [CW-1:0]      disc_q, disc_d;
    logic [CW-1:0]      occ;
    logic [CW:0]        credit_sum;
    logic               req_fire, rsp_accept, rsp_live, ent_pop;
    logic [31:0]        pcf_rdata;
    logic               pcf_full, pcf_empty, ent_full, ent_empty;
    logic [CW-1:0]      pcf_count;
    logic [ENTRY_W-1:0] ent_rdata;
    fetch_entry_t       head, push_entry;
    logic               unused_ok;

    // Outstanding requests reserve queue slots, so a response can always be pushed.
    assign credit_sum       = {1'b0, occ} + {1'b0, out_q};
    assign imem_req_valid_o = !rst_i && !taken_branch_i && (credit_sum < DEPTH_L);
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign rsp_accept = imem_rsp_valid_i && (out_q != '0);
    assign rsp_live   = rsp_accept && (disc_q == '0) && !taken_branch_i && !pcf_empty;
    assign ent_pop    = valid_o && !stall_i && !taken_branch_i;

    assign push_entry = '{pc: pcf_rdata, instr: imem_rsp_data_i};
    assign head       = fetch_entry_t'(ent_rdata);
    assign valid_o    = !ent_empty;
    assign pc_o       = ent_empty ? 32'h0 : head.pc;
    assign instr_o    = ent_empty ? NOP_INSTR_HEX : head.instr;

    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q;
        disc_d = disc_q;
        if (req_fire) begin
            pc_d  = pc_q + PC_STEP;
            out_d = out_q + CW'(1);
        end
        if (rsp_accept) begin
            out_d = out_d - CW'(1);
        end
        // Everything still in flight after this cycle belongs to the old path.
        if (taken_branch_i) begin
            pc_d   = new_pc_i;
            disc_d = out_d;
        end else if (rsp_accept && (disc_q != '0)) begin
            disc_d = disc_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            disc_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            disc_q <= disc_d;
        end
    end

    fifo_sync #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (taken_branch_i),
        .push_i  (req_fire),
        .wdata_i (pc_q),
        .pop_i   (rsp_live),
        .rdata_o (pcf_rdata),
        .full_o  (pcf_full),
        .empty_o (pcf_empty),
        .count_o (pcf_count)
    );

    fifo_sync #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (taken_branch_i),
        .push_i  (rsp_live),
        .wdata_i (push_entry),
        .pop_i   (ent_pop),
        .rdata_o (ent_rdata),
        .full_o  (ent_full),
        .empty_o (ent_empty),
        .count_o (occ)
    );

    assign unused_ok = &{1'b0, pcf_full, pcf_count, ent_full};

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: reset, streaming, stall credit limit, redirects
// with in-flight responses, and a memory that withholds ready.
module tb_fetch_buffer;

    logic        clk, rst, taken, stall, req_ready, rsp_valid;
    logic [31:0] new_pc, rsp_data;
    logic        req_valid, valid_o;
    logic [31:0] req_addr, pc_o, instr_o;

    int n_checks = 0;
    int n_errors = 0;
    int req_fires = 0;
    bit mem_auto = 1'b0;

    fetch_buffer dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .taken_branch_i   (taken),
        .new_pc_i         (new_pc),
        .stall_i          (stall),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .pc_o             (pc_o),
        .instr_o          (instr_o),
        .valid_o          (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Advance one cycle; returns #1 after the next rising edge. With mem_auto set
    // the bench behaves as a 1-cycle memory answering each accepted request.
    task automatic cycle();
        logic        fire;
        logic [31:0] a;
        @(negedge clk);
        fire = req_valid && req_ready;
        a    = req_addr;
        if (fire) req_fires++;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            rsp_valid = fire;
            rsp_data  = fire ? instr_of(a) : 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_auto = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
        taken = 1'b0; new_pc = 32'h0; stall = 1'b0; req_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        req_fires = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; taken = 1'b0; new_pc = 32'h0; stall = 1'b0;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_req_valid: got %0h expected 0", req_valid); end
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0h expected 0", valid_o); end
        n_checks++; if (instr_o !== 32'h0000_0013) begin n_errors++; $display("FAIL rst_instr: got %h expected 00000013", instr_o); end
        n_checks++; if (pc_o !== 32'h0) begin n_errors++; $display("FAIL rst_pc: got %h expected 00000000", pc_o); end
        n_checks++; if (req_addr !== 32'h0) begin n_errors++; $display("FAIL rst_addr: got %h expected 00000000", req_addr); end
        rsp_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (req_valid !== 1'b1) begin n_errors++; $display("FAIL rst_release_req: got %0h expected 1", req_valid); end
        $display("reset: done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_auto = 1'b1;
        n_checks++; if (req_addr !== 32'h0) begin n_errors++; $display("FAIL b2b_addr0: got %h expected 00000000", req_addr); end
        cycle();
        n_checks++; if (req_addr !== 32'h4) begin n_errors++; $display("FAIL b2b_addr1: got %h expected 00000004", req_addr); end
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL b2b_valid_early: got %0h expected 0", valid_o); end
        cycle();
        n_checks++; if (req_addr !== 32'h8) begin n_errors++; $display("FAIL b2b_addr2: got %h expected 00000008", req_addr); end
        n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL b2b_valid: got %0h expected 1", valid_o); end
        n_checks++; if (pc_o !== 32'h0) begin n_errors++; $display("FAIL b2b_pc0: got %h expected 00000000", pc_o); end
        n_checks++; if (instr_o !== instr_of(32'h0)) begin n_errors++; $display("FAIL b2b_instr0: got %h expected %h", instr_o, instr_of(32'h0)); end
        cycle();
        n_checks++; if (pc_o !== 32'h4) begin n_errors++; $display("FAIL b2b_pc1: got %h expected 00000004", pc_o); end
        cycle();
        n_checks++; if (pc_o !== 32'h8) begin n_errors++; $display("FAIL b2b_pc2: got %h expected 00000008", pc_o); end
        n_checks++; if (req_fires !== 4) begin n_errors++; $display("FAIL b2b_fires: got %0d expected 4", req_fires); end
        $display("back_to_back: %0d requests issued", req_fires);
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1;
        mem_auto = 1'b1;
        repeat (10) cycle();
        n_checks++; if (req_fires !== 4) begin n_errors++; $display("FAIL stall_fires: got %0d expected 4", req_fires); end
        n_checks++; if (req_valid !== 1'b0) begin n_errors++; $display("FAIL stall_req_valid: got %0h expected 0", req_valid); end
        n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL stall_valid: got %0h expected 1", valid_o); end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(i * 4);
            n_checks++; if (pc_o !== exp_pc) begin n_errors++; $display("FAIL stall_pop_pc%0d: got %h expected %h", i, pc_o, exp_pc); end
            n_checks++; if (instr_o !== instr_of(exp_pc)) begin n_errors++; $display("FAIL stall_pop_instr%0d: got %h expected %h", i, instr_o, instr_of(exp_pc)); end
            $display("stall: pop pc=%h instr=%h", pc_o, instr_o);
            cycle();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        n_checks++; if (req_addr !== 32'h0) begin n_errors++; $display("FAIL redir_addr0: got %h expected 00000000", req_addr); end
        cycle();
        n_checks++; if (req_addr !== 32'h4) begin n_errors++; $display("FAIL redir_addr1: got %h expected 00000004", req_addr); end
        cycle();
        taken = 1'b1; new_pc = 32'h100;
        #1;
        n_checks++; if (req_valid !== 1'b0) begin n_errors++; $display("FAIL redir_req_blocked: got %0h expected 0", req_valid); end
        cycle();
        taken = 1'b0; rsp_valid = 1'b1; rsp_data = instr_of(32'h0);
        #1;
        n_checks++; if (req_addr !== 32'h100) begin n_errors++; $display("FAIL redir_new_addr: got %h expected 00000100", req_addr); end
        n_checks++; if (req_valid !== 1'b1) begin n_errors++; $display("FAIL redir_req_resume: got %0h expected 1", req_valid); end
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL redir_empty: got %0h expected 0", valid_o); end
        cycle();
        rsp_data = instr_of(32'h4);
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL redir_drop1: got valid %0h pc %h expected 0", valid_o, pc_o); end
        cycle();
        rsp_data = instr_of(32'h100);
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL redir_drop2: got valid %0h pc %h expected 0", valid_o, pc_o); end
        cycle();
        rsp_valid = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL redir_valid: got %0h expected 1", valid_o); end
        n_checks++; if (pc_o !== 32'h100) begin n_errors++; $display("FAIL redir_pc: got %h expected 00000100", pc_o); end
        n_checks++; if (instr_o !== instr_of(32'h100)) begin n_errors++; $display("FAIL redir_instr: got %h expected %h", instr_o, instr_of(32'h100)); end
        $display("redirect: first pc after redirect %h", pc_o);
    endtask

    task automatic test_redirect_collision();
        do_reset();
        cycle();
        rsp_valid = 1'b1; rsp_data = instr_of(32'h0);
        cycle();
        rsp_valid = 1'b0; stall = 1'b1;
        #1;
        n_checks++; if (pc_o !== 32'h0 || valid_o !== 1'b1) begin n_errors++; $display("FAIL coll_head: got valid %0h pc %h expected 1 00000000", valid_o, pc_o); end
        cycle();
        stall = 1'b0; taken = 1'b1; new_pc = 32'h200;
        rsp_valid = 1'b1; rsp_data = instr_of(32'h4);
        #1;
        n_checks++; if (req_valid !== 1'b0) begin n_errors++; $display("FAIL coll_req_blocked: got %0h expected 0", req_valid); end
        cycle();
        taken = 1'b0; rsp_data = instr_of(32'h8);
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL coll_flushed: got %0h expected 0", valid_o); end
        n_checks++; if (req_addr !== 32'h200) begin n_errors++; $display("FAIL coll_new_addr: got %h expected 00000200", req_addr); end
        n_checks++; if (req_valid !== 1'b1) begin n_errors++; $display("FAIL coll_req_resume: got %0h expected 1", req_valid); end
        cycle();
        rsp_data = instr_of(32'h200);
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL coll_drop: got valid %0h pc %h expected 0", valid_o, pc_o); end
        n_checks++; if (req_addr !== 32'h204) begin n_errors++; $display("FAIL coll_addr_next: got %h expected 00000204", req_addr); end
        cycle();
        rsp_valid = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL coll_valid: got %0h expected 1", valid_o); end
        n_checks++; if (pc_o !== 32'h200) begin n_errors++; $display("FAIL coll_pc: got %h expected 00000200", pc_o); end
        n_checks++; if (instr_o !== instr_of(32'h200)) begin n_errors++; $display("FAIL coll_instr: got %h expected %h", instr_o, instr_of(32'h200)); end
        $display("redirect_collision: head pc %h", pc_o);
    endtask

    task automatic test_ready_low();
        do_reset();
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rsp_valid = (i >= 1); rsp_data = 32'hDEAD_BEEF;
            #1;
            n_checks++; if (req_valid !== 1'b1) begin n_errors++; $display("FAIL ready_low_valid%0d: got %0h expected 1", i, req_valid); end
            n_checks++; if (req_addr !== 32'h0) begin n_errors++; $display("FAIL ready_low_addr%0d: got %h expected 00000000", i, req_addr); end
            cycle();
        end
        rsp_valid = 1'b0; req_ready = 1'b1;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL spurious_push: got %0h expected 0", valid_o); end
        cycle();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = instr_of(32'h0);
        #1;
        n_checks++; if (req_addr !== 32'h4) begin n_errors++; $display("FAIL ready_addr_next: got %h expected 00000004", req_addr); end
        cycle();
        rsp_valid = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin n_errors++; $display("FAIL ready_rsp: got valid %0h pc %h expected 1 00000000", valid_o, pc_o); end
        n_checks++; if (instr_o !== instr_of(32'h0)) begin n_errors++; $display("FAIL ready_instr: got %h expected %h", instr_o, instr_of(32'h0)); end
        $display("ready_low: addr held, spurious responses ignored");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_redirect_collision();
        test_ready_low();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
